// File: rtl/layer4_result_mem_ctrl_pkg.sv
// Shared types and constants for the layer-4 result buffer sequencer.
package layer4_result_mem_ctrl_pkg;

  localparam int L4_ADDR_W = 16;
  localparam int L5_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/layer4_raster_cnt.sv
// Row/column raster counter: synchronous clear, advance, wrap at WIDTH-1,
// and a flag marking the last cell of the WIDTH x WIDTH frame.
module layer4_raster_cnt #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [CNT_W-1:0] row_o,
  output logic [CNT_W-1:0] col_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             col_last_s;
  logic             row_last_s;

  always_comb begin
    col_last_s = (col_q == LAST_IDX);
    row_last_s = (row_q == LAST_IDX);
    row_d      = row_q;
    col_d      = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      // Row also wraps so the final transfer leaves the counter at (0,0).
      if (col_last_s) begin
        col_d = '0;
        row_d = row_last_s ? '0 : (row_q + ONE);
      end else begin
        col_d = col_q + ONE;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = col_last_s & row_last_s;

endmodule

// File: rtl/layer4_result_mem_ctrl.sv
// Layer-4 result buffer sequencer: raster write phase, then raster replay to layer 5.
// Optional LAYER4_CTRL_ERR_EN adds a sticky error flag for dropped words / stray starts.
module layer4_result_mem_ctrl
  import layer4_result_mem_ctrl_pkg::*;
#(
  parameter int WIDTH  = L5_WIDTH,
  parameter int ADDR_W = L4_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              save_enable,
  output logic [ADDR_W-1:0] save_row_addr,
  output logic [ADDR_W-1:0] save_col_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              layer4_result_read_signal,
  output logic [ADDR_W-1:0] read_row_addr,
  output logic [ADDR_W-1:0] read_col_addr,
  output logic              busy,
`ifdef LAYER4_CTRL_ERR_EN
  output logic              err_sticky,
`endif
  output logic              frame_done
);

  state_e            state_q, state_d;
  logic              cnt_clr_s;
  logic              cnt_adv_s;
  logic [ADDR_W-1:0] row_s;
  logic [ADDR_W-1:0] col_s;
  logic              last_s;

  // Write and read phases never overlap, so a single counter serves both.
  layer4_raster_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (ADDR_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr_s),
    .adv_i  (cnt_adv_s),
    .row_o  (row_s),
    .col_o  (col_s),
    .last_o (last_s)
  );

  always_comb begin
    state_d                   = state_q;
    cnt_clr_s                 = 1'b0;
    cnt_adv_s                 = 1'b0;
    wr_ready                  = 1'b0;
    save_enable               = 1'b0;
    save_row_addr             = '0;
    save_col_addr             = '0;
    rd_valid                  = 1'b0;
    layer4_result_read_signal = 1'b0;
    read_row_addr             = '0;
    read_col_addr             = '0;
    busy                      = (state_q != ST_IDLE);
    frame_done                = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr_s = 1'b1;
        if (start) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        wr_ready      = 1'b1;
        save_enable   = wr_valid;
        save_row_addr = row_s;
        save_col_addr = col_s;
        cnt_adv_s     = wr_valid;
        if (wr_valid && last_s) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        rd_valid                  = 1'b1;
        layer4_result_read_signal = 1'b1;
        read_row_addr             = row_s;
        read_col_addr             = col_s;
        cnt_adv_s                 = rd_ready;
        if (rd_ready && last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef LAYER4_CTRL_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (wr_valid && (state_q != ST_WRITE))
          | (start && (state_q != ST_IDLE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_layer4_result_mem_ctrl.sv
// Randomized self-checking bench: WIDTH=4 and WIDTH=1 controllers share stimulus
// and are checked every cycle against a transfer-count reference model.
module tb_layer4_result_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, wr_valid, rd_ready;
  logic        wr_ready_o[2], save_en_o[2], rd_valid_o[2], rd_sig_o[2], busy_o[2], done_o[2];
  logic [15:0] srow_o[2], scol_o[2], rrow_o[2], rcol_o[2];
`ifdef LAYER4_CTRL_ERR_EN
  logic        err_o[2];
`endif

  int checks = 0;
  int failures = 0;
  int wv[2] = '{4, 1};
  // Model phase: 0 idle, 1 writing, 2 reading, 3 done pulse; k = transfers so far.
  int m_phase[2];
  int m_k[2];
  bit m_err[2];
  int save_cnt;
  int done_cnt;

  layer4_result_mem_ctrl #(.WIDTH(4), .ADDR_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .wr_valid(wr_valid), .wr_ready(wr_ready_o[0]),
    .save_enable(save_en_o[0]), .save_row_addr(srow_o[0]), .save_col_addr(scol_o[0]),
    .rd_valid(rd_valid_o[0]), .rd_ready(rd_ready), .layer4_result_read_signal(rd_sig_o[0]),
    .read_row_addr(rrow_o[0]), .read_col_addr(rcol_o[0]), .busy(busy_o[0]),
`ifdef LAYER4_CTRL_ERR_EN
    .err_sticky(err_o[0]),
`endif
    .frame_done(done_o[0])
  );

  layer4_result_mem_ctrl #(.WIDTH(1), .ADDR_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .wr_valid(wr_valid), .wr_ready(wr_ready_o[1]),
    .save_enable(save_en_o[1]), .save_row_addr(srow_o[1]), .save_col_addr(scol_o[1]),
    .rd_valid(rd_valid_o[1]), .rd_ready(rd_ready), .layer4_result_read_signal(rd_sig_o[1]),
    .read_row_addr(rrow_o[1]), .read_col_addr(rcol_o[1]), .busy(busy_o[1]),
`ifdef LAYER4_CTRL_ERR_EN
    .err_sticky(err_o[1]),
`endif
    .frame_done(done_o[1])
  );

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic check_dut(input int d);
    int  w;
    bit  wr;
    bit  rd;
    w  = wv[d];
    wr = (m_phase[d] == 1);
    rd = (m_phase[d] == 2);
    chk("wr_ready",    d, 32'(wr_ready_o[d]), 32'(wr));
    chk("save_enable", d, 32'(save_en_o[d]),  32'(wr && wr_valid));
    chk("save_row",    d, 32'(srow_o[d]),     wr ? m_k[d] / w : 0);
    chk("save_col",    d, 32'(scol_o[d]),     wr ? m_k[d] % w : 0);
    chk("rd_valid",    d, 32'(rd_valid_o[d]), 32'(rd));
    chk("read_signal", d, 32'(rd_sig_o[d]),   32'(rd));
    chk("read_row",    d, 32'(rrow_o[d]),     rd ? m_k[d] / w : 0);
    chk("read_col",    d, 32'(rcol_o[d]),     rd ? m_k[d] % w : 0);
    chk("busy",        d, 32'(busy_o[d]),     32'(m_phase[d] != 0));
    chk("frame_done",  d, 32'(done_o[d]),     32'(m_phase[d] == 3));
`ifdef LAYER4_CTRL_ERR_EN
    chk("err_sticky",  d, 32'(err_o[d]),      32'(m_err[d]));
`endif
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0;
      m_k[d]     = 0;
      m_err[d]   = 1'b0;
    end
  endtask

  task automatic model_clock(input int d);
    int n;
    n = wv[d] * wv[d];
    if (rst) begin
      m_phase[d] = 0;
      m_k[d]     = 0;
      m_err[d]   = 1'b0;
    end else begin
      if ((wr_valid && m_phase[d] != 1) || (start && m_phase[d] != 0)) m_err[d] = 1'b1;
      case (m_phase[d])
        0: if (start) begin m_phase[d] = 1; m_k[d] = 0; end
        1: if (wr_valid) begin
             m_k[d]++;
             if (m_k[d] == n) begin m_phase[d] = 2; m_k[d] = 0; end
           end
        2: if (rd_ready) begin
             m_k[d]++;
             if (m_k[d] == n) begin m_phase[d] = 3; m_k[d] = 0; end
           end
        default: m_phase[d] = 0;
      endcase
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_dut(d);
    save_cnt += int'(save_en_o[0]);
    done_cnt += int'(done_o[0]);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_clock(d);
    #1;
  endtask

  // mode 0: back-to-back writes, rd_ready 1,0,0; mode 1: writes every other cycle; mode 2: random
  task automatic run_frame(input int mode, input bit count_check);
    int cyc;
    save_cnt = 0;
    done_cnt = 0;
    start = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
    step();
    cyc = 0;
    while (m_phase[0] != 0 && cyc < 300) begin
      start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
      if (m_phase[0] == 1) begin
        wr_valid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        rd_ready = 1'($urandom_range(0, 1));
      end else if (m_phase[0] == 2) begin
        rd_ready = (mode == 0) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
        wr_valid = 1'($urandom_range(0, 1));
        start    = (cyc % 5 == 0);
      end
      step();
      cyc++;
    end
    chk("frame_timeout", 0, 32'(m_phase[0]), 32'd0);
    if (count_check) begin
      chk("save_pulses", 0, 32'(save_cnt), 32'd16);
      chk("done_pulses", 0, 32'(done_cnt), 32'd1);
    end
    start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    model_reset();
    #1;
    step();
    step();
    rst = 1'b0;
    step();

    run_frame(0, 1'b1);
    run_frame(1, 1'b1);
    run_frame(2, 1'b1);

    // Reset in the middle of the write phase, after seven transfers.
    start = 1'b1;
    step();
    start = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    wr_valid = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) check_dut(d);
    step();
    rst = 1'b0;
    step();
    run_frame(2, 1'b1);
    run_frame(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
